shape_scheduler: RTL

//  Command front-end for computationalcore. Queues 96-bit draw opcodes from the host

---
 rtl/gpu_pkg.sv | 21 ++
 rtl/cmd_fifo.sv | 56 +++++
 rtl/shape_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared types and constants for the shape scheduler front-end.
package gpu_pkg;

  localparam int OPC_W   = 96;
  localparam int ADDR_W  = 19;
  localparam int COLOR_W = 16;

  localparam logic [3:0] CMD_SWAP = 4'hF;
  localparam logic [3:0] CMD_NOP  = 4'hE;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } sched_state_t;

  // Command type lives in the top nibble of every opcode.
  function automatic logic [3:0] cmd_type(input logic [OPC_W-1:0] opc);
    return opc[OPC_W-1 -: 4];
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count.
// The head entry only becomes visible on the cycle after it was written.
module cmd_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = wr_en & ~full;
  assign do_pop  = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  // NOTE: leaving the memory out of reset lets it map onto plain RAM/flops without reset muxes.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/shape_scheduler.sv
// Command front-end: queues draw opcodes, issues them to the raster core,
// relays pixels to the frame-buffer writer, executes buffer swaps between
// shapes and aborts a shape whose core goes silent for WATCHDOG cycles.
module shape_scheduler
  import gpu_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WATCHDOG = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [OPC_W-1:0]   cmd_opcode,
  output logic               cmd_ready,
  output logic               core_new_shape,
  output logic [OPC_W-1:0]   core_opcode,
  input  logic               core_shape_done,
  input  logic               core_data_ready,
  input  logic [ADDR_W-1:0]  core_address,
  input  logic [COLOR_W-1:0] core_color,
  output logic               core_data_sent,
  output logic               fb_wr_en,
  output logic [ADDR_W:0]    fb_addr,
  output logic [COLOR_W-1:0] fb_wdata,
  input  logic               fb_wr_ack,
  output logic               front_buffer,
  output logic               frame_swap,
  output logic               busy,
  output logic               abort_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int WD_W  = $clog2(WATCHDOG);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG - 1);

  sched_state_t     state, state_nxt;
  logic             rdy_en;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [OPC_W-1:0] head;
  logic             push, pop;
  logic             start_shape, do_swap;
  logic             done_pending;
  logic             relay_latch, relay_ack;
  logic             wd_quiet, wd_abort;
  logic [WD_W-1:0]  wd_cnt;

  // cmd_ready stays low through reset and for the first edge after release.
  assign cmd_ready = rdy_en & ~fifo_full;
  assign push      = cmd_valid & cmd_ready;
  assign busy      = (fifo_count != '0) | (state != IDLE) | fb_wr_en;

  // One pixel in flight at most: no new latch while holding or while data_sent pulses.
  assign relay_ack   = (state == DRAW) & fb_wr_en & fb_wr_ack;
  assign relay_latch = (state == DRAW) & ~fb_wr_en & ~core_data_sent & core_data_ready;

  assign wd_quiet = ~core_data_ready & ~core_shape_done & ~fb_wr_ack;
  assign wd_abort = (state == DRAW) & wd_quiet & (wd_cnt == WD_LAST);

  cmd_fifo #(
    .WIDTH (OPC_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (cmd_opcode),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Scheduler state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode: dispatch the FIFO head in IDLE, wait for shape completion in DRAW.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_nxt   = state;
    pop         = 1'b0;
    start_shape = 1'b0;
    do_swap     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (cmd_type(head) == CMD_SWAP) begin
            do_swap = 1'b1;
          end else if (cmd_type(head) != CMD_NOP) begin
            start_shape = 1'b1;
            state_nxt   = DRAW;
          end
        end
      end
      DRAW: begin
        if (wd_abort) begin
          state_nxt = IDLE;
        end else if ((done_pending || core_shape_done) && !relay_latch &&
                     (!fb_wr_en || fb_wr_ack)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shape issue: opcode capture, start pulse, abort pulse and ready enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en         <= 1'b0;
      core_new_shape <= 1'b0;
      core_opcode    <= '0;
      abort_err      <= 1'b0;
    end else begin
      rdy_en         <= 1'b1;
      core_new_shape <= start_shape;
      abort_err      <= wd_abort;
      if (start_shape) core_opcode <= head;
    end
  end

  // Remember a shape_done that arrived while a pixel was still waiting for its ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        done_pending <= 1'b0;
    else if (state == DRAW && state_nxt == DRAW)    done_pending <= done_pending | core_shape_done;
    else                                            done_pending <= 1'b0;
  end

  // Pixel relay: latch one pixel into the back buffer, hold until acked, then pulse data_sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_wr_en       <= 1'b0;
      fb_addr        <= '0;
      fb_wdata       <= '0;
      core_data_sent <= 1'b0;
    end else begin
      core_data_sent <= relay_ack;
      if (wd_abort || relay_ack) begin
        fb_wr_en <= 1'b0;
      end else if (relay_latch) begin
        fb_wr_en <= 1'b1;
        fb_addr  <= {~front_buffer, core_address};
        fb_wdata <= core_color;
      end
    end
  end

  // Watchdog: counts consecutive silent DRAW cycles, cleared by any core/writer activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   wd_cnt <= '0;
    else if (state != DRAW || !wd_quiet || wd_abort) wd_cnt <= '0;
    else                                       wd_cnt <= wd_cnt + 1'b1;
  end

  // Double-buffer select; toggles only when a SWAP command is popped in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_buffer <= 1'b0;
      frame_swap   <= 1'b0;
    end else begin
      frame_swap <= do_swap;
      if (do_swap) front_buffer <= ~front_buffer;
    end
  end

endmodule
